// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO slice.
// Optional feature macro: UART_RX_FIFO_ERR_DROP_EN (see uart_rx_fifo.sv).
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  // Capture FSM state encoding, kept as plain constants for legacy compatibility
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACK  = 2'd1;
  localparam state_t WAIT = 2'd2;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver handshake and consumer pop channel of the UART receive FIFO.
// master: receiver + consumer side; slave: the FIFO itself.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  rcvd;
  logic [DATA_WIDTH-1:0] datarx;
  logic                  rx_err;
  logic                  rxack;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;
  logic                  drdy;

  modport master (output rcvd, datarx, rx_err, drdy, input rxack, dout, dvalid);
  modport slave  (input rcvd, datarx, rx_err, drdy, output rxack, dout, dvalid);

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read so the
// head entry is visible without a read cycle (show-ahead). Contents are not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: acknowledges each byte from the receiver exactly once and
// queues it for a show-ahead consumer. A byte arriving while full is still
// acknowledged but dropped, setting the sticky overflow flag.
// Optional: define UART_RX_FIFO_ERR_DROP_EN to discard bytes flagged rx_err.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_rx_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic            rxack_q, rxack_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            take, err_drop, wr_en, rd_en, drop;
  logic [DATA_WIDTH-1:0] rdata;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign err_drop = bus.rx_err;
`else
  logic rx_err_unused;
  assign rx_err_unused = bus.rx_err;
  assign err_drop      = 1'b0;
`endif

  // Full is judged on occupancy before this cycle's pop
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign take  = (state_q == IDLE) && bus.rcvd;
  assign wr_en = take && !full && !err_drop;
  assign drop  = take && full && !err_drop;
  assign rd_en = !empty && bus.drdy;

  // Capture FSM: one acknowledge per held rcvd
  always_comb begin
    state_d = state_q;
    rxack_d = 1'b0;
    case (state_q)
      IDLE: if (bus.rcvd) begin
        rxack_d = 1'b1;
        state_d = ACK;
      end
      ACK:  state_d = WAIT;
      WAIT: if (!bus.rcvd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, occupancy and sticky overflow update (drop wins over clear)
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(rd_en);
    count_d    = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rxack_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxack_q    <= rxack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (bus.datarx),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Storage is unreset, so dout is masked to zero whenever nothing is held
  assign bus.dout   = empty ? '0 : rdata;
  assign bus.dvalid = !empty;
  assign bus.rxack  = rxack_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width taken from the UART receiver.
REQ-002 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single system clock (100 MHz, 115200 baud link); all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rcvd  input  1  receiver has a byte on datarx; held high until acknowledged.
REQ-006 datarx  input  DATA_WIDTH  received byte; stable while rcvd=1.
REQ-007 rx_err  input  1  framing error for the current datarx; qualified by rcvd.
REQ-008 rxack  output  1  one-cycle acknowledge pulse to the receiver.
REQ-009 dout  output  DATA_WIDTH  head-of-FIFO byte (show-ahead).
REQ-010 dvalid  output  1  dout holds a valid byte.
REQ-011 drdy  input  1  consumer pops the head when dvalid && drdy.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 full, empty  output  1 each  count==DEPTH / count==0.
REQ-014 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-015 ovf_clr  input  1  clears overflow.

Function
REQ-016 Capture FSM SHALL have states IDLE, ACK, WAIT.
REQ-017 IDLE, rcvd=1: next edge writes datarx, or drops it if full (sets overflow); rxack<=1; go to ACK.
REQ-018 ACK: rxack<=0; go to WAIT. rxack SHALL be high for exactly one cycle per byte.
REQ-019 WAIT: stay until rcvd=0, then IDLE; one held rcvd SHALL never produce two writes.
REQ-020 Full FIFO SHALL still acknowledge the receiver (drain it); the byte is discarded.
REQ-021 Full check uses occupancy before the current cycle's pop; a same-cycle pop does not rescue a write to a full FIFO.
REQ-022 Write latency: byte on dout with dvalid=1 one cycle after the write edge when previously empty.
REQ-023 Pop when dvalid && drdy; drdy with empty FIFO SHALL be ignored (no underflow, count stays 0).
REQ-024 Simultaneous write and pop with 0<count<DEPTH: count unchanged, both take effect.
REQ-025 Read/write pointers $clog2(DEPTH) bits, wrap modulo DEPTH without extra logic.
REQ-026 ovf_clr and a same-cycle drop: set wins; overflow stays 1.

Reset
REQ-027 rst_n low SHALL asynchronously force: FSM IDLE, pointers 0, count 0, empty=1, full=0, dvalid=0, rxack=0, overflow=0, dout=0.
REQ-028 Reset mid-handshake (ACK or WAIT) aborts; after release a still-high rcvd is treated as a new byte.
REQ-029 Storage array contents need not be reset.

Configuration
REQ-030 Macro UART_RX_FIFO_ERR_DROP_EN.
REQ-031 Defined: a byte with rx_err=1 SHALL be acknowledged but not written; overflow unaffected.
REQ-032 Undefined: rx_err ignored; every acknowledged byte is written when space exists.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state typedef (IDLE/ACK/WAIT) and the DATA_WIDTH default constant.
REQ-034 One sub-module, uart_fifo_mem: dual-pointer DEPTH x DATA_WIDTH storage with async read for show-ahead.

Verification
REQ-035 Reset, then serial byte 0x8E (bits LSB first 0,1,1,1,0,0,0,1) into upstream receiver -> one rxack pulse, dout=0x8E, dvalid=1, count=1.
REQ-036 rcvd held high 200 cycles with 0x8E -> exactly one write, count=1.
REQ-037 DEPTH=16, drdy=0, 17 bytes 0x00..0x10 -> full=1, 17 rxack pulses, overflow=1, pops yield 0x00..0x0F in order.
REQ-038 Write 0xA5 in the same cycle as popping 0x3C at count=5 -> count stays 5, next dout per FIFO order.
REQ-039 With UART_RX_FIFO_ERR_DROP_EN, byte 0xED with rx_err=1 -> rxack pulse, count unchanged; without the macro -> count+1, dout=0xED.
REQ-040 rst_n low during WAIT with 3 bytes stored -> count=0, empty=1, dvalid=0, rxack=0 immediately.
